thresholding_cfg_loader: RTL and testbench

//  AXI4-Lite master that programs a thresholding_axi instance from an AXI-Stream of threshold words.

---
 rtl/thresholding_pkg.sv | 31 +++
 rtl/axil_wr_chan.sv | 42 ++++
 rtl/thresholding_cfg_loader.sv | 188 ++++++++++++++++++
 tb/tb_thresholding_cfg_loader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thresholding_pkg.sv
// Shared definitions for the thresholding cfg loader:
// AXI-Lite response codes, FSM states and the cfg address map.
package thresholding_pkg;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WADDR,
    ST_BRESP,
    ST_RADDR,
    ST_RDATA,
    ST_DONE
  } cfg_state_e;

  // Byte address of threshold t of channel (cf, pe)
  function automatic logic [31:0] thr_addr(
    input logic [31:0] cf,
    input logic [31:0] pe,
    input logic [31:0] t,
    input int unsigned pe_bits,
    input int unsigned n
  );
    return (cf << (pe_bits + n + 2)) |
           (pe << (n + 2)) |
           (t << 2);
  endfunction

endpackage

// File: rtl/axil_wr_chan.sv
// AXI-Lite write channel joiner: raises AW and W together and
// drops each on its own handshake; accepted marks both done.
module axil_wr_chan (
  input  logic clk,
  input  logic rst,
  input  logic launch,
  input  logic awready,
  input  logic wready,
  output logic awvalid,
  output logic wvalid,
  output logic accepted
);

  logic aw_q, aw_d;
  logic w_q, w_d;

  always_comb begin
    aw_d = aw_q && !awready;
    w_d  = w_q && !wready;
    if (launch) begin
      aw_d = 1'b1;
      w_d  = 1'b1;
    end
  end

  assign awvalid  = aw_q;
  assign wvalid   = w_q;
  assign accepted = (aw_q || w_q) &&
                    (!aw_q || awready) &&
                    (!w_q || wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_q <= 1'b0;
      w_q  <= 1'b0;
    end else begin
      aw_q <= aw_d;
      w_q  <= w_d;
    end
  end

endmodule

// File: rtl/thresholding_cfg_loader.sv
// AXI4-Lite master that writes (and optionally verifies) every
// threshold word of a thresholding_axi instance from a stream.
module thresholding_cfg_loader
  import thresholding_pkg::*;
#(
  parameter int N      = 4,
  parameter int K      = 10,
  parameter int C      = 6,
  parameter int PE     = 2,
  parameter int VERIFY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         err_wr,
  output logic         err_rd,
  input  logic         s_thr_tvalid,
  output logic         s_thr_tready,
  input  logic [K-1:0] s_thr_tdata,
  output logic         m_AWVALID,
  input  logic         m_AWREADY,
  output logic [$clog2(C/PE)+$clog2(PE)+N+1:0] m_AWADDR,
  output logic         m_WVALID,
  input  logic         m_WREADY,
  output logic [31:0]  m_WDATA,
  output logic [3:0]   m_WSTRB,
  input  logic         m_BVALID,
  output logic         m_BREADY,
  input  logic [1:0]   m_BRESP,
  output logic         m_ARVALID,
  input  logic         m_ARREADY,
  output logic [$clog2(C/PE)+$clog2(PE)+N+1:0] m_ARADDR,
  input  logic         m_RVALID,
  output logic         m_RREADY,
  input  logic [31:0]  m_RDATA,
  input  logic [1:0]   m_RRESP
);

  localparam int CF        = C / PE;
  localparam int PE_BITS   = $clog2(PE);
  localparam int ADDR_BITS = $clog2(CF) + PE_BITS + N + 2;
  localparam int T_W       = N;
  localparam int PE_W      = (PE > 1) ? $clog2(PE) : 1;
  localparam int CF_W      = (CF > 1) ? $clog2(CF) : 1;

  localparam logic [T_W-1:0]  T_MAX  = T_W'(2**N - 2);
  localparam logic [PE_W-1:0] PE_MAX = PE_W'(PE - 1);
  localparam logic [CF_W-1:0] CF_MAX = CF_W'(CF - 1);

  cfg_state_e state_q, state_d;
  logic [K-1:0]    word_q, word_d;
  logic [T_W-1:0]  t_q, t_d;
  logic [PE_W-1:0] pe_q, pe_d;
  logic [CF_W-1:0] cf_q, cf_d;
  logic            err_wr_q, err_wr_d;
  logic            err_rd_q, err_rd_d;

  logic            launch;
  logic            adv;
  logic            last;
  logic            wr_accepted;
  logic [31:0]     addr_full;

  axil_wr_chan u_wr (
    .clk      (clk),
    .rst      (rst),
    .launch   (launch),
    .awready  (m_AWREADY),
    .wready   (m_WREADY),
    .awvalid  (m_AWVALID),
    .wvalid   (m_WVALID),
    .accepted (wr_accepted)
  );

  assign last = (t_q == T_MAX) &&
                (pe_q == PE_MAX) &&
                (cf_q == CF_MAX);

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    t_d      = t_q;
    pe_d     = pe_q;
    cf_d     = cf_q;
    err_wr_d = err_wr_q;
    err_rd_d = err_rd_q;
    launch   = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          err_wr_d = 1'b0;
          err_rd_d = 1'b0;
          t_d      = '0;
          pe_d     = '0;
          cf_d     = '0;
        end
      end
      ST_FETCH: begin
        if (s_thr_tvalid) begin
          word_d  = s_thr_tdata;
          launch  = 1'b1;
          state_d = ST_WADDR;
        end
      end
      ST_WADDR: begin
        if (wr_accepted) state_d = ST_BRESP;
      end
      ST_BRESP: begin
        if (m_BVALID) begin
          if (m_BRESP != AXI_OKAY) err_wr_d = 1'b1;
          if (VERIFY != 0) state_d = ST_RADDR;
          else adv = 1'b1;
        end
      end
      ST_RADDR: begin
        if (m_ARREADY) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (m_RVALID) begin
          if ((m_RRESP != AXI_OKAY) ||
              (m_RDATA != 32'(word_q)))
            err_rd_d = 1'b1;
          adv = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Word completion folds the counter step into the same cycle
    if (adv) begin
      state_d = last ? ST_DONE : ST_FETCH;
      if (t_q == T_MAX) begin
        t_d = '0;
        if (pe_q == PE_MAX) begin
          pe_d = '0;
          cf_d = cf_q + 1'b1;
        end else begin
          pe_d = pe_q + 1'b1;
        end
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      word_q   <= '0;
      t_q      <= '0;
      pe_q     <= '0;
      cf_q     <= '0;
      err_wr_q <= 1'b0;
      err_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      t_q      <= t_d;
      pe_q     <= pe_d;
      cf_q     <= cf_d;
      err_wr_q <= err_wr_d;
      err_rd_q <= err_rd_d;
    end
  end

  assign addr_full = thr_addr(32'(cf_q), 32'(pe_q),
                              32'(t_q), PE_BITS, N);

  assign m_AWADDR     = ADDR_BITS'(addr_full);
  assign m_ARADDR     = ADDR_BITS'(addr_full);
  assign m_WDATA      = 32'(word_q);
  assign m_WSTRB      = 4'hF;
  assign m_BREADY     = (state_q == ST_BRESP);
  assign m_ARVALID    = (state_q == ST_RADDR);
  assign m_RREADY     = (state_q == ST_RDATA);
  assign s_thr_tready = (state_q == ST_FETCH);
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE) &&
                        (state_q != ST_DONE);
  assign err_wr       = err_wr_q;
  assign err_rd       = err_rd_q;

endmodule

// File: tb/tb_thresholding_cfg_loader.sv
// Scoreboard bench for thresholding_cfg_loader
// (N=2, C=4, PE=2, VERIFY=1) against a small AXI-Lite slave.
module tb_thresholding_cfg_loader;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err_wr, err_rd;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [9:0]  tdata = '0;
  logic        awvalid, awready;
  logic [5:0]  awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [5:0]  araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int b_cnt = 0;
  exp_t exp_q[$];

  int aw_wait = 0;
  int w_wait = 0;
  int bresp_idx = -1;
  int corrupt_idx = -1;

  logic [5:0] addr_tbl [12] = '{
    6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18,
    6'h20, 6'h24, 6'h28, 6'h30, 6'h34, 6'h38
  };

  always #5 clk = ~clk;

  thresholding_cfg_loader #(
    .N(2), .K(10), .C(4), .PE(2), .VERIFY(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err_wr       (err_wr),
    .err_rd       (err_rd),
    .s_thr_tvalid (tvalid),
    .s_thr_tready (tready),
    .s_thr_tdata  (tdata),
    .m_AWVALID    (awvalid),
    .m_AWREADY    (awready),
    .m_AWADDR     (awaddr),
    .m_WVALID     (wvalid),
    .m_WREADY     (wready),
    .m_WDATA      (wdata),
    .m_WSTRB      (wstrb),
    .m_BVALID     (bvalid),
    .m_BREADY     (bready),
    .m_BRESP      (bresp),
    .m_ARVALID    (arvalid),
    .m_ARREADY    (arready),
    .m_ARADDR     (araddr),
    .m_RVALID     (rvalid),
    .m_RREADY     (rready),
    .m_RDATA      (rdata),
    .m_RRESP      (rresp)
  );

  // AXI-Lite slave with per-channel wait states and fault injection
  int          aw_cnt, w_cnt;
  logic        have_aw, have_w;
  logic [5:0]  aw_l;
  logic [31:0] w_l;
  logic [31:0] mem [16];

  assign awready = awvalid && (aw_cnt >= aw_wait);
  assign wready  = wvalid && (w_cnt >= w_wait);
  assign arready = arvalid;
  assign rresp   = 2'b00;

  function automatic bit is_idx(logic [5:0] a, int idx);
    if (idx < 0) return 1'b0;
    return a == addr_tbl[idx];
  endfunction

  always @(posedge clk) begin : slave
    logic        aw_now, w_now;
    logic [5:0]  a_now;
    logic [31:0] d_now;
    if (rst) begin
      aw_cnt  <= 0;
      w_cnt   <= 0;
      have_aw <= 1'b0;
      have_w  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      if (awvalid && awready) aw_cnt <= 0;
      else if (awvalid) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready) w_cnt <= 0;
      else if (wvalid) w_cnt <= w_cnt + 1;
      if (bvalid && bready) bvalid <= 1'b0;
      aw_now = have_aw || (awvalid && awready);
      w_now  = have_w || (wvalid && wready);
      a_now  = have_aw ? aw_l : awaddr;
      d_now  = have_w ? w_l : wdata;
      if (aw_now && w_now) begin
        mem[a_now[5:2]] <= d_now;
        bvalid  <= 1'b1;
        bresp   <= is_idx(a_now, bresp_idx) ? 2'b10 : 2'b00;
        have_aw <= 1'b0;
        have_w  <= 1'b0;
      end else begin
        if (awvalid && awready) begin
          have_aw <= 1'b1;
          aw_l    <= awaddr;
        end
        if (wvalid && wready) begin
          have_w <= 1'b1;
          w_l    <= wdata;
        end
      end
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= mem[araddr[5:2]] ^
                  (is_idx(araddr, corrupt_idx) ? 32'h1 : 32'h0);
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: pairs each B handshake with the oldest expected write
  initial begin : monitor
    logic        aw_seen, w_seen;
    logic [5:0]  aw_a;
    logic [31:0] w_d;
    exp_t        e;
    aw_seen = 1'b0;
    w_seen  = 1'b0;
    aw_a    = '0;
    w_d     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end else begin
        if (done) begin
          done_cnt++;
          chk("busy_at_done", 32'(busy), 0);
        end
        if (awvalid && awready) begin
          chk("aw_once", 32'(aw_seen), 0);
          aw_seen = 1'b1;
          aw_a    = awaddr;
        end
        if (wvalid && wready) begin
          chk("w_once", 32'(w_seen), 0);
          chk("wstrb", 32'(wstrb), 32'hF);
          w_seen = 1'b1;
          w_d    = wdata;
        end
        if (bvalid && bready) begin
          b_cnt++;
          if (exp_q.size() == 0) begin
            chk("b_extra", 32'(b_cnt), 0);
          end else begin
            e = exp_q.pop_front();
            chk("aw_w_both", 32'({aw_seen, w_seen}), 32'h3);
            chk("awaddr", 32'(aw_a), 32'(e.a));
            chk("wdata", w_d, e.d);
          end
          aw_seen = 1'b0;
          w_seen  = 1'b0;
        end
      end
    end
  end

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    done_cnt = 0;
    b_cnt    = 0;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_clr_err", 32'({err_wr, err_rd}), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic push_word(input logic [9:0] v,
                           input int gap, input int idx);
    exp_t e;
    int   n;
    repeat (gap) @(posedge clk);
    #1;
    tdata  = v;
    tvalid = 1'b1;
    e.a = addr_tbl[idx];
    e.d = {22'd0, v};
    exp_q.push_back(e);
    n = 0;
    @(negedge clk);
    while (!tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("tready_timeout", 1, 0);
    @(posedge clk);
    #1 tvalid = 1'b0;
  endtask

  task automatic wait_done(input logic ewr, input logic erd);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("done_timeout", 1, 0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt), 1);
    chk("b_count", 32'(b_cnt), 12);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("err_wr", 32'(err_wr), 32'(ewr));
    chk("err_rd", 32'(err_rd), 32'(erd));
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic run_load(input int base, input bit gaps,
                          input bit dup, input logic ewr,
                          input logic erd);
    do_start();
    fork
      begin
        for (int i = 0; i < 12; i++)
          push_word(10'(base + i), gaps ? (i * 7) % 11 : 0, i);
      end
      begin
        if (dup) begin
          repeat (15) @(posedge clk);
          #1 start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
        end
      end
    join
    wait_done(ewr, erd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out", 32'({busy, done, err_wr, err_rd}), 0);
    chk("rst_valid", 32'({awvalid, wvalid, arvalid}), 0);
    chk("rst_ready", 32'({bready, rready, tready}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_tready", 32'(tready), 0);

    run_load(1, 1'b0, 1'b0, 1'b0, 1'b0);

    aw_wait = 0;
    w_wait  = 3;
    run_load(100, 1'b0, 1'b0, 1'b0, 1'b0);
    aw_wait = 3;
    w_wait  = 0;
    run_load(200, 1'b0, 1'b0, 1'b0, 1'b0);
    aw_wait = 0;

    bresp_idx = 4;
    run_load(300, 1'b0, 1'b0, 1'b1, 1'b0);
    bresp_idx = -1;

    corrupt_idx = 6;
    run_load(400, 1'b0, 1'b0, 1'b0, 1'b1);
    corrupt_idx = -1;
    run_load(500, 1'b0, 1'b0, 1'b0, 1'b0);

    run_load(600, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("dup_start_ignored", 32'(busy), 0);

    aw_wait = 10;
    do_start();
    push_word(10'h3FF, 0, 0);
    n = 0;
    @(negedge clk);
    while (!awvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("awvalid_before_rst", 32'(awvalid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'({awvalid, wvalid, arvalid}), 0);
    chk("midrst_busy", 32'(busy), 0);
    exp_q.delete();
    rst = 1'b0;
    aw_wait = 0;
    run_load(700, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
